// File: rtl/mac_requant.sv
// mac_requant: bias add, Q31 scale, rounding shift, zero point and clamp
// to int8 activations; 4-stage valid/ready pipeline with saturation counter.
module mac_requant #(
  parameter int ACC_WIDTH  = 16,
  parameter int BIAS_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic signed [BIAS_WIDTH-1:0] bias_i,
  input  logic signed [31:0]           quant_mult_i,
  input  logic [4:0]                   quant_shift_i,
  input  logic signed [OUT_WIDTH-1:0]  out_zp_i,
  input  logic signed [OUT_WIDTH-1:0]  act_min_i,
  input  logic signed [OUT_WIDTH-1:0]  act_max_i,
  output logic signed [OUT_WIDTH-1:0]  data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [CNT_WIDTH-1:0]         sat_count
);

  localparam int SW = BIAS_WIDTH + 1;
  localparam int PW = SW + 32;
  localparam int RW = PW + 1;

  logic stall;
  logic adv;

  assign stall     = valid_out && !ready_in;
  assign adv       = !stall;
  assign ready_out = adv;

  logic                        v1, v2, v3;
  logic signed [SW-1:0]        s1_sum;
  logic signed [31:0]          s1_mult;
  logic [4:0]                  s1_shift, s2_shift;
  logic signed [OUT_WIDTH-1:0] s1_zp, s2_zp, s3_zp;
  logic signed [OUT_WIDTH-1:0] s1_lo, s2_lo, s3_lo;
  logic signed [OUT_WIDTH-1:0] s1_hi, s2_hi, s3_hi;
  logic signed [PW-1:0]        s2_prod;
  logic signed [RW-1:0]        s3_r;

  logic signed [SW-1:0]        sum_in;
  logic [5:0]                  n;
  logic [RW-1:0]               half;
  logic signed [RW-1:0]        biased;
  logic signed [RW-1:0]        r_next;
  logic signed [RW-1:0]        v;
  logic                        below;
  logic                        above;
  logic                        sat;
  logic signed [OUT_WIDTH-1:0] clamped;

  assign sum_in = SW'(acc_i) + SW'(bias_i);

  // Round half toward +inf: add 2^(n-1) before the arithmetic shift.
  always_comb begin
    n      = 6'd31 + {1'b0, s2_shift};
    half   = RW'(1) << (n - 6'd1);
    biased = RW'(s2_prod) + $signed(half);
    r_next = biased >>> n;
  end

  // The max bound is applied last, so an inverted range yields act_max.
  always_comb begin
    v       = s3_r + RW'(s3_zp);
    below   = v < RW'(s3_lo);
    above   = v > RW'(s3_hi);
    sat     = below || above;
    clamped = v[OUT_WIDTH-1:0];
    if (below)
      clamped = s3_lo;
    if (above || (below && (s3_lo > s3_hi)))
      clamped = s3_hi;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sum   <= sum_in;
      s1_mult  <= quant_mult_i;
      s1_shift <= quant_shift_i;
      s1_zp    <= out_zp_i;
      s1_lo    <= act_min_i;
      s1_hi    <= act_max_i;
      s2_prod  <= PW'(s1_sum) * PW'(s1_mult);
      s2_shift <= s1_shift;
      s2_zp    <= s1_zp;
      s2_lo    <= s1_lo;
      s2_hi    <= s1_hi;
      s3_r     <= r_next;
      s3_zp    <= s2_zp;
      s3_lo    <= s2_lo;
      s3_hi    <= s2_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      sat_count <= '0;
    end else if (adv) begin
      v1        <= valid_in;
      v2        <= v1;
      v3        <= v2;
      valid_out <= v3;
      if (v3) begin
        data_out <= clamped;
        if (sat && (sat_count != '1))
          sat_count <= sat_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
